// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, fetch miss, data-memory freeze.
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_FREEZE = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  imem_busy,
  input  logic                  dmem_busy,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  ifid_kill,
  output logic                  idex_hold,
  output logic                  idex_kill,
  output logic                  exmem_hold,
  output logic                  exmem_kill,
  output logic                  memwb_hold,
  output logic                  memwb_kill,
  output logic                  freeze_timeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  // state  | meaning
  // RUN    | pipeline advancing, hazards resolved by bubbles/flushes
  // FREEZE | data memory busy, every stage held
  typedef enum logic {RUN, FREEZE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] FRZ_LIMIT = CNT_W'(MAX_FREEZE - 1);

  state_t           fsm_q, fsm_d;
  logic             pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0] frz_cnt_q, frz_cnt_d;
  logic             timeout_q, timeout_d;

  logic load_use;
  logic flush_req;
  logic frz_c, flush_c, lu_c, im_c;
  logic timeout_hit;

  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign flush_req = ex_branch_taken | pend_flush_q;

  // Priority chain: memory freeze, flush, load-use bubble, fetch miss.
  assign frz_c   = dmem_busy;
  assign flush_c = !dmem_busy && flush_req;
  assign lu_c    = !dmem_busy && !flush_req && load_use;
  assign im_c    = !dmem_busy && !flush_req && !load_use && imem_busy;

  assign timeout_hit = dmem_busy && (frz_cnt_q >= FRZ_LIMIT);

  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_kill  = 1'b0;
    idex_hold  = 1'b0;
    idex_kill  = 1'b0;
    exmem_hold = 1'b0;
    exmem_kill = 1'b0;
    memwb_hold = 1'b0;
    memwb_kill = 1'b0;
    if (rst) begin
      pc_hold    = 1'b1;
      ifid_kill  = 1'b1;
      idex_kill  = 1'b1;
      exmem_kill = 1'b1;
      memwb_kill = 1'b1;
    end else if (frz_c) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      memwb_hold = 1'b1;
    end else if (flush_c) begin
      ifid_kill  = 1'b1;
      idex_kill  = 1'b1;
    end else if (lu_c) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_kill  = 1'b1;
    end else if (im_c) begin
      pc_hold    = 1'b1;
      ifid_kill  = 1'b1;
    end
  end

  assign freeze_timeout = !rst && (timeout_q || timeout_hit);

  always_comb begin
    fsm_d        = fsm_q;
    pend_flush_d = pend_flush_q;
    frz_cnt_d    = frz_cnt_q;
    timeout_d    = timeout_q || timeout_hit;
    if (dmem_busy) begin
      fsm_d = FREEZE;
      // A branch resolved while EX is frozen must be replayed on exit.
      if (ex_branch_taken) pend_flush_d = 1'b1;
      if (frz_cnt_q != CNT_MAX) frz_cnt_d = frz_cnt_q + CNT_W'(1);
    end else begin
      if (fsm_q == FREEZE) begin
        fsm_d     = RUN;
        frz_cnt_d = '0;
      end
      if (flush_c) pend_flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= RUN;
      pend_flush_q <= 1'b0;
      frz_cnt_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      pend_flush_q <= pend_flush_d;
      frz_cnt_q    <= frz_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_hold && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_c && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl, built with MAX_FREEZE=4.
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rs, id_uses_rt, ex_is_load, ex_branch_taken, imem_busy, dmem_busy;
  logic pc_hold, ifid_hold, ifid_kill, idex_hold, idex_kill;
  logic exmem_hold, exmem_kill, memwb_hold, memwb_kill, freeze_timeout;
`ifdef PIPE_HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .MAX_FREEZE(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_kill(ifid_kill),
    .idex_hold(idex_hold), .idex_kill(idex_kill),
    .exmem_hold(exmem_hold), .exmem_kill(exmem_kill),
    .memwb_hold(memwb_hold), .memwb_kill(memwb_kill),
    .freeze_timeout(freeze_timeout)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // {pc_hold, ifid_hold, ifid_kill, idex_hold, idex_kill, exmem_hold, exmem_kill, memwb_hold, memwb_kill, freeze_timeout}
  localparam logic [9:0] RST_V = 10'b1010101010;
  localparam logic [9:0] IDLE  = 10'b0000000000;
  localparam logic [9:0] FRZ   = 10'b1101010100;
  localparam logic [9:0] FLUSH = 10'b0010100000;
  localparam logic [9:0] LU    = 10'b1100100000;
  localparam logic [9:0] IM    = 10'b1010000000;
  localparam logic [9:0] TO    = 10'b0000000001;

  wire [9:0] obs = {pc_hold, ifid_hold, ifid_kill, idex_hold, idex_kill,
                    exmem_hold, exmem_kill, memwb_hold, memwb_kill, freeze_timeout};

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];
  string      tag_q[$];

  task automatic step(input logic r, input logic [AW-1:0] rs, input logic urs,
                      input logic [AW-1:0] rt, input logic urt, input logic ld,
                      input logic [AW-1:0] rd, input logic br, input logic im,
                      input logic dm, input logic [9:0] e, input string tag);
    logic [9:0] ev;
    string      t;
    logic       both;
    @(negedge clk);
    rst = r; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    ex_is_load = ld; ex_rd = rd; ex_branch_taken = br; imem_busy = im; dmem_busy = dm;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    ev = exp_q.pop_front();
    t  = tag_q.pop_front();
    checks++;
    assert (obs === ev) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b", t, obs, ev);
    end
    if (!r) begin
      both = (ifid_hold & ifid_kill) | (idex_hold & idex_kill) |
             (exmem_hold & exmem_kill) | (memwb_hold & memwb_kill);
      checks++;
      assert (both === 1'b0) else begin
        failures++;
        $error("FAIL %s_hold_kill_overlap obs=%b exp=0", t, both);
      end
    end
  endtask

  task automatic idle(input logic [9:0] e, input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, tag);
  endtask

  task automatic busy(input logic br, input logic [9:0] e, input string tag);
    step(0, 0, 0, 0, 0, 0, 0, br, 0, 1, e, tag);
  endtask

  task automatic reset_cyc(input logic dm, input string tag);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, dm, RST_V, tag);
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic chk_cnt(input string tag, input logic [CW-1:0] o, input logic [CW-1:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_is_load = 1'b0; ex_branch_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;

    reset_cyc(1, "rst_busy0");
    reset_cyc(1, "rst_busy1");
    idle(IDLE, "post_reset_idle");

    step(0, 5, 1, 0, 0, 1, 5, 0, 0, 0, LU,   "lu_rs");
    idle(IDLE, "lu_one_bubble");
    step(0, 3, 1, 7, 1, 1, 7, 0, 0, 0, LU,   "lu_rt");
    step(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, IDLE, "lu_rd_zero");
    step(0, 5, 0, 2, 1, 1, 5, 0, 0, 0, IDLE, "lu_rs_unused");
    step(0, 5, 1, 0, 0, 0, 5, 0, 0, 0, IDLE, "no_load");

    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FLUSH, "branch");
    idle(IDLE, "branch_done");
    step(0, 5, 1, 0, 0, 1, 5, 1, 1, 0, FLUSH, "branch_over_lu");

    busy(0, FRZ,      "frz_c1");
    busy(1, FRZ,      "frz_c2_branch");
    busy(0, FRZ,      "frz_c3");
    busy(0, FRZ | TO, "frz_c4_to");
    idle(FLUSH | TO,  "frz_exit_flush");
    idle(IDLE | TO,   "frz_single_flush");
    reset_cyc(0, "rst_clear_to");
    idle(IDLE, "to_cleared");

    step(0, 5, 1, 0, 0, 1, 5, 0, 1, 1, FRZ, "frz_over_all_a");
    step(0, 5, 1, 0, 0, 1, 5, 0, 1, 1, FRZ, "frz_over_all_b");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, IM,  "frz_exit_imem");
    busy(0, FRZ, "cnt_cleared_1");
    busy(0, FRZ, "cnt_cleared_2");
    busy(0, FRZ, "cnt_cleared_3");
    idle(IDLE, "short_freeze_exit");

    busy(1, FRZ, "mid_frz_branch");
    reset_cyc(1, "mid_frz_reset");
    idle(IDLE, "pend_flush_dropped");

    for (int i = 1; i <= 6; i++) busy(0, (i >= 4) ? (FRZ | TO) : FRZ, $sformatf("to_busy%0d", i));
    idle(IDLE | TO, "to_sticky_a");
    idle(IDLE | TO, "to_sticky_b");
    reset_cyc(0, "to_rst");
    idle(IDLE, "to_rst_clear");

    reset_cyc(0, "perf_rst");
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, IM, $sformatf("imem%0d", i));
`ifdef PIPE_HAZARD_PERF_EN
    @(posedge clk); #1;
    chk_cnt("stall_cnt_imem", stall_cnt, 16'd3);
    chk_cnt("flush_cnt_imem", flush_cnt, 16'd0);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FLUSH, "perf_branch");
`ifdef PIPE_HAZARD_PERF_EN
    @(posedge clk); #1;
    chk_cnt("flush_cnt_branch", flush_cnt, 16'd1);
    chk_cnt("stall_cnt_branch", stall_cnt, 16'd3);
`endif
    idle(IDLE, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control-side counterpart of the per-stage pipeline registers. It generates every hold (stall) and kill (flush) signal they consume.
- Serves the 5-stage IF/ID/EX/MEM/WB core and sits beside the register file and branch unit.
- Detects load-use hazards, taken branches, instruction-fetch misses and multi-cycle data-memory waits, then sequences the per-register hold/kill pairs.
- Tracks memory freezes with a small FSM plus a watchdog counter.

Parameters:
REG_ADDR_W, 5, register specifier width.
MAX_FREEZE, 64, freeze cycles allowed before the timeout flag sets (must be >= 1).
CNT_W, 16, width of freeze counter and of the optional performance counters.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, synchronous, active-high.
id_rs  in  REG_ADDR_W  source reg A of the instruction in ID.
id_rt  in  REG_ADDR_W  source reg B of the instruction in ID.
id_uses_rs  in  1  ID instruction reads rs.
id_uses_rt  in  1  ID instruction reads rt.
ex_is_load  in  1  instruction in EX is a load.
ex_rd  in  REG_ADDR_W  destination of the EX instruction.
ex_branch_taken  in  1  branch resolved taken in EX this cycle.
imem_busy  in  1  fetch not ready this cycle.
dmem_busy  in  1  data memory access in MEM not complete.
pc_hold  out  1  PC keeps its value.
ifid_hold, ifid_kill  out  1 each  IF/ID register control.
idex_hold, idex_kill  out  1 each  ID/EX register control.
exmem_hold, exmem_kill  out  1 each  EX/MEM register control.
memwb_hold, memwb_kill  out  1 each  MEM/WB register control.
freeze_timeout  out  1  sticky error flag.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Outputs are combinational from the registered state plus current inputs. Zero-cycle latency: the stall or flush takes effect at the same edge the hazard is sampled.
- Internal state: fsm ∈ {RUN, FREEZE}, pend_flush (1 bit), frz_cnt (CNT_W bits).
- load_use = ex_is_load & ex_rd != 0 & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- While rst=1:
  - All hold=0.
  - All four kills=1, pc_hold=1.
  - Next state: fsm=RUN, pend_flush=0, frz_cnt=0, freeze_timeout=0.
- Evaluation order each cycle (first match wins):
  1. dmem_busy=1: all four holds=1 and pc_hold=1; all kills=0.
     - fsm->FREEZE.
     - If ex_branch_taken=1, set pend_flush (it is lost otherwise, because EX is frozen).
     - frz_cnt increments, saturating at max.
     - When frz_cnt reaches MAX_FREEZE-1 while busy, freeze_timeout sets and stays set until rst.
  2. ex_branch_taken | pend_flush: ifid_kill=1, idex_kill=1; all other outputs 0 (PC loads target).
     - pend_flush clears.
  3. load_use: pc_hold=1, ifid_hold=1, idex_kill=1; all others 0.
     - Exactly one bubble; the next cycle the load is in MEM, so no repeat.
  4. imem_busy: pc_hold=1, ifid_kill=1; all others 0.
  5. Otherwise all outputs 0.
- FREEZE exit: the first cycle with dmem_busy=0 evaluates rules 2-5 as above. In that cycle fsm->RUN and frz_cnt->0.
- Invariant: hold and kill of the same register are never both 1 outside reset. A checker flags a violation.
- Reset asserted mid-FREEZE abandons the freeze and any pending flush immediately.
- The pipeline register gives kill priority over hold; this block must not rely on that.

Optional Feature:
PIPE_HAZARD_PERF_EN:
- Defined: adds outputs stall_cnt [CNT_W] and flush_cnt [CNT_W], both saturating and cleared by rst.
  - stall_cnt increments on every cycle with pc_hold=1 outside reset.
  - flush_cnt increments on every cycle where rule 2 fires.
- Undefined: these ports and counters do not exist. Functional outputs are identical in both builds.

Test Plan:
1. Reset: rst=1 for 2 cycles with dmem_busy=1 -> all kills=1, holds=0; after release with idle inputs, all outputs 0 and freeze_timeout=0.
2. Load-use: ex_is_load=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> for exactly 1 cycle pc_hold=ifid_hold=idex_kill=1. With ex_rd=0 -> no stall.
3. Branch: ex_branch_taken=1 for 1 cycle -> ifid_kill=idex_kill=1, pc_hold=0. Branch and load-use in the same cycle -> flush only.
4. Freeze with deferred flush: dmem_busy=1 for 4 cycles with ex_branch_taken=1 in cycle 2 -> all holds=1 for 4 cycles, then exactly one flush cycle on exit.
5. Timeout: MAX_FREEZE=4, dmem_busy held 6 cycles -> freeze_timeout rises on the 4th busy cycle, stays 1 after busy drops, clears only with rst.
6. imem_busy=1 alone for 3 cycles -> pc_hold=ifid_kill=1 each cycle. With PIPE_HAZARD_PERF_EN defined, stall_cnt=3 and flush_cnt=0 afterwards.
